nibble_write_loader: RTL
========================

Name: nibble_write_loader

Overview:
- Upstream feeder for the 8x16 register file write port.
- Assembles a full 16-bit write word from four 4-bit switch entries, MSB nibble first; each entry is committed by a debounced one-shot button pulse.
- Issues exactly one single-cycle write strobe with a stable address and data.
- Replaces the fixed upper-nibble padding on the write path, so any 16-bit value can be loaded into any register.

Parameters:
- TIMEOUT_CYCLES, 100_000_000: idle cycles allowed between nibble entries before a partial word is discarded (1 s at 100 MHz).
- TO_W, 27: timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_pulse  input  1  one-cycle-wide enter strobe from one_shot.
- abort  input  1  level; discards a word under assembly.
- nib_in  input  4  switch nibble sampled on btn_pulse.
- adr_in  input  3  target register address, sampled on the first nibble only.
- W_Adr  output  3  registered write address to the register file.
- W_Data  output  16  registered assembled write word.
- we  output  1  registered one-cycle write strobe.
- busy  output  1  high in COLLECT or WRITE.
- nib_cnt  output  2  nibbles accepted for the current word (0-3).
- timeout  output  1  one-cycle pulse when a partial word is discarded by timeout.

Behaviour:
- Reset: the clock and reset ports are clk and reset; one clock, and reset is synchronous and active-high. Reset takes effect at the next rising edge from any state. It clears W_Adr=0, W_Data=16'h0000, we=0, busy=0, nib_cnt=0, timeout=0, the accumulator and the timeout counter, and sets state=IDLE. A word under assembly at reset is lost; no we is issued.
- States: IDLE, COLLECT, WRITE.
- IDLE, btn_pulse=1 and abort=0:
  - acc[15:12] <= nib_in; W_Adr <= adr_in; nib_cnt <= 1; timeout counter cleared.
  - Next state COLLECT.
- COLLECT, btn_pulse=1 and abort=0:
  - Nibble written to slot (3 - nib_cnt), i.e. acc[11:8], then [7:4], then [3:0].
  - nib_cnt increments; timeout counter cleared.
  - On the 4th nibble: W_Data <= {acc[15:4], nib_in}; nib_cnt <= 0; next state WRITE.
- WRITE:
  - we=1 for exactly this one cycle, then state returns to IDLE.
  - btn_pulse and abort are ignored in WRITE; the write always completes.
- Latency: if the 4th btn_pulse is sampled at edge k, we is high from edge k to edge k+1, with W_Adr and W_Data already valid.
- W_Adr and W_Data hold their values after the write until the next word begins (W_Adr) or completes (W_Data).
- adr_in changes after the first nibble have no effect on the current word.
- Abort: abort=1 in COLLECT returns to IDLE at the next edge with nib_cnt=0 and W_Data unchanged. If abort and btn_pulse are high in the same cycle, abort wins and the nibble is dropped. abort has no effect in IDLE.
- Timeout:
  - The counter increments each COLLECT cycle without a pulse.
  - When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE, nib_cnt=0 and timeout=1 for one cycle.
  - A btn_pulse in that same cycle is accepted instead; pulse beats timeout.
- busy is combinational from state: 1 in COLLECT or WRITE, 0 in IDLE.
- A btn_pulse held high for several cycles is treated as several entries; the upstream one_shot guarantees single-cycle pulses.

Test Plan:
- Reset, then pulses with nib_in=A,B,C,D and adr_in=5 at the first pulse -> we high exactly one cycle after the 4th pulse, W_Adr=5, W_Data=16'hABCD, nib_cnt sequence 1,2,3,0.
- adr_in changed 5->2 after the first nibble, data 1,2,3,4 -> W_Adr=5, W_Data=16'h1234.
- Two nibbles entered, then abort=1 -> IDLE, nib_cnt=0, no we, W_Data keeps its previous value. Next, abort and btn_pulse together in COLLECT -> nibble dropped.
- TIMEOUT_CYCLES=8, one nibble entered, then no pulses -> timeout pulse 8 cycles later, busy=0, no we. A pulse arriving on the timeout cycle -> accepted, nib_cnt=2, no timeout pulse.
- Reset asserted after 3 nibbles -> all outputs 0 at the next edge, no we. A 4th pulse after reset -> treated as a first nibble, nib_cnt=1.
- btn_pulse during the WRITE cycle -> ignored, state returns to IDLE, nib_cnt=0. Back-to-back words FFFF then 0000 -> two we strobes with correct data.

Source files
------------

// File: rtl/nibble_write_loader.sv
// -----------------------------------------------------------------------------
// nibble_write_loader
//
// Front end for the 8x16 register file write port. Builds one 16-bit word
// from four 4-bit switch entries, most significant nibble first. Each entry is
// committed by a single-cycle button pulse. When the fourth nibble arrives,
// the module issues one write strobe with a stable address and data.
// A partially entered word is thrown away if abort is raised, if reset is
// asserted, or if no entry arrives for TIMEOUT_CYCLES cycles.
//
// Ports
//   clk        in   1   system clock, all state changes on the rising edge
//   reset      in   1   synchronous active-high reset
//   btn_pulse  in   1   one-cycle enter strobe (from one_shot)
//   abort      in   1   level, discards the word being assembled
//   nib_in     in   4   switch nibble, sampled on btn_pulse
//   adr_in     in   3   target register, sampled with the first nibble only
//   W_Adr      out  3   registered write address
//   W_Data     out  16  registered assembled write word
//   we         out  1   registered single-cycle write strobe
//   busy       out  1   high while collecting or writing
//   nib_cnt    out  2   nibbles accepted so far for the current word
//   timeout    out  1   one-cycle pulse when a partial word times out
// -----------------------------------------------------------------------------
module nibble_write_loader #(
   parameter int TIMEOUT_CYCLES = 100_000_000,
   parameter int TO_W           = 27
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_pulse,
   input  logic        abort,
   input  logic [3:0]  nib_in,
   input  logic [2:0]  adr_in,
   output logic [2:0]  W_Adr,
   output logic [15:0] W_Data,
   output logic        we,
   output logic        busy,
   output logic [1:0]  nib_cnt,
   output logic        timeout
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      WRITE   = 2'd2
   } state_t;

   state_t            state_reg;
   logic [2:0]        adr_reg;
   logic [15:0]       data_reg;
   logic              we_reg;
   logic              timeout_reg;
   logic [1:0]        nib_cnt_reg;
   logic [TO_W-1:0]   to_cnt_reg;
   logic [15:0]       acc;

   // A nibble is taken in IDLE or COLLECT when abort is low. In WRITE the
   // pulse is ignored so the write always completes.
   logic accept;
   assign accept = btn_pulse && !abort && (state_reg != WRITE);

   logic to_expire;
   assign to_expire = (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

   // Accumulator slots. nib_cnt_reg is 0 in IDLE, so the first nibble lands
   // in slot 3 (acc[15:12]) and later nibbles fill slots 2, 1 and 0.
   // Slot 0 is loaded for completeness; the final nibble goes straight into
   // data_reg so the word is valid in the same cycle as the strobe.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : gen_slot
         logic [3:0] slot_reg;

         always_ff @(posedge clk) begin
            if (reset) begin
               slot_reg <= 4'h0;
            end else if (accept && (nib_cnt_reg == 2'(3 - gi))) begin
               slot_reg <= nib_in;
            end
         end

         assign acc[4*gi +: 4] = slot_reg;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         adr_reg     <= 3'd0;
         data_reg    <= 16'h0000;
         we_reg      <= 1'b0;
         timeout_reg <= 1'b0;
         nib_cnt_reg <= 2'd0;
         to_cnt_reg  <= '0;
      end else begin
         we_reg      <= 1'b0;
         timeout_reg <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (accept) begin
                  adr_reg     <= adr_in;
                  nib_cnt_reg <= 2'd1;
                  to_cnt_reg  <= '0;
                  state_reg   <= COLLECT;
               end
            end

            COLLECT: begin
               if (abort) begin
                  // Abort wins over a simultaneous pulse; W_Data is untouched.
                  nib_cnt_reg <= 2'd0;
                  to_cnt_reg  <= '0;
                  state_reg   <= IDLE;
               end else if (btn_pulse) begin
                  // A pulse also wins over a timeout in the same cycle.
                  to_cnt_reg <= '0;
                  if (nib_cnt_reg == 2'd3) begin
                     data_reg    <= {acc[15:4], nib_in};
                     nib_cnt_reg <= 2'd0;
                     we_reg      <= 1'b1;
                     state_reg   <= WRITE;
                  end else begin
                     nib_cnt_reg <= nib_cnt_reg + 2'd1;
                  end
               end else if (to_expire) begin
                  nib_cnt_reg <= 2'd0;
                  to_cnt_reg  <= '0;
                  timeout_reg <= 1'b1;
                  state_reg   <= IDLE;
               end else begin
                  to_cnt_reg <= to_cnt_reg + 1'b1;
               end
            end

            WRITE: begin
               state_reg <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign W_Adr   = adr_reg;
   assign W_Data  = data_reg;
   assign we      = we_reg;
   assign timeout = timeout_reg;
   assign nib_cnt = nib_cnt_reg;
   assign busy    = (state_reg != IDLE);

endmodule
